decode_stage: RTL and testbench



---
 rtl/decode_stage_pkg.sv | 76 +++++++
 rtl/decode_stage_if.sv | 27 ++
 rtl/regfile_param.sv | 27 ++
 rtl/decode_stage.sv | 98 +++++++++
 tb/tb_decode_stage.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared opcode/ALU/immediate types, the id_beat_t pipeline register and decode helpers.
package decode_stage_pkg;
    localparam int DATA_W = 32;

    typedef enum logic [6:0] {
        OP_LOAD = 7'h03, OP_IMM = 7'h13, OP_AUIPC = 7'h17, OP_STORE = 7'h23, OP_REG = 7'h33,
        OP_LUI = 7'h37, OP_BRANCH = 7'h63, OP_JALR = 7'h67, OP_JAL = 7'h6F
    } opcode_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_t;

    typedef enum logic [2:0] {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_X} imm_t;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        opcode_t           opcode;
        logic [2:0]        funct3;
        alu_op_t           alu_control;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rd;
        logic              reg_write;
        logic              illegal;
    } id_beat_t;

    function automatic imm_t fmt_of(logic [6:0] op);
        case (op)
            OP_REG: return IMM_R;
            OP_IMM, OP_LOAD, OP_JALR: return IMM_I;
            OP_STORE: return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_LUI, OP_AUIPC: return IMM_U;
            OP_JAL: return IMM_J;
            default: return IMM_X;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] imm_extend(imm_t fmt, logic [31:0] i);
        case (fmt)
            IMM_I: return {{20{i[31]}}, i[31:20]};
            IMM_S: return {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U: return {i[31:12], 12'b0};
            IMM_J: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return '0;
        endcase
    endfunction

    // ALU decoder: branches compare via SUB/SLT/SLTU, address-forming ops use ADD, LUI passes the immediate.
    function automatic alu_op_t alu_decode(opcode_t op, logic [2:0] f3, logic f7b5);
        alu_op_t arith;
        case (f3)
            3'b000: arith = (op == OP_REG && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001: arith = ALU_SLL;
            3'b010: arith = ALU_SLT;
            3'b011: arith = ALU_SLTU;
            3'b100: arith = ALU_XOR;
            3'b101: arith = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110: arith = ALU_OR;
            default: arith = ALU_AND;
        endcase
        case (op)
            OP_REG, OP_IMM: return arith;
            OP_BRANCH: return f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
            OP_LUI: return ALU_PASSB;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic reg_ok(logic [4:0] idx, int nregs);
        return nregs == 32 || !idx[4];
    endfunction
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and execute-side valid/ready handshakes of the decode stage.
interface decode_stage_if
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            in_valid, in_ready, flush;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid, out_ready, out_reg_write, out_illegal;
    logic [XLEN-1:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
    opcode_t         out_opcode;
    logic [2:0]      out_funct3;
    alu_op_t         out_alu_control;
    logic [4:0]      out_rd;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_funct3, out_alu_control,
               out_rs1_data, out_rs2_data, out_imm, out_rd, out_reg_write, out_illegal
    );
    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_funct3, out_alu_control,
               out_rs1_data, out_rs2_data, out_imm, out_rd, out_reg_write, out_illegal
    );
endinterface

// File: rtl/regfile_param.sv
// regfile_param: NUM_REGS x XLEN register file, two async reads, one sync write, x0 reads zero.
module regfile_param
    import decode_stage_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int XLEN = 32,
    parameter int AW = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);
    logic [XLEN-1:0] mem [NUM_REGS];

    always_ff @(posedge clk or negedge reset)
        if (!reset) for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        else if (we && waddr != 5'd0 && reg_ok(waddr, NUM_REGS)) mem[waddr[AW-1:0]] <= wdata;

    assign rd1 = (ra1 != 5'd0 && reg_ok(ra1, NUM_REGS)) ? mem[ra1[AW-1:0]] : '0;
    assign rd2 = (ra2 != 5'd0 && reg_ok(ra2, NUM_REGS)) ? mem[ra2[AW-1:0]] : '0;
endmodule

// File: rtl/decode_stage.sv
// decode_stage: pipelined RV32I/RV32E decode with valid/ready on both sides and an internal regfile.
// Define DECODE_WB_BYPASS_EN to forward same-cycle writebacks into captured and held operands.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NUM_REGS = 32
) (
    input logic            clk,
    input logic            reset,
    decode_stage_if.slave  bus,
    input logic            wb_en,
    input logic [4:0]      wb_rd,
    input logic [XLEN-1:0] wb_data
);
    localparam int REG_AW = $clog2(NUM_REGS);

    if (NUM_REGS != 32 && NUM_REGS != 16) begin : g_bad_regs
        $error("NUM_REGS must be 16 (RV32E) or 32 (RV32I)");
    end
    if (XLEN != DATA_W) begin : g_bad_xlen
        $error("XLEN must match the id_beat_t datapath width");
    end

    imm_t              fmt;
    logic [4:0]        rs1, rs2, rd;
    logic              illegal, accept, valid_q;
    logic [XLEN-1:0]   rd1, rd2;
    id_beat_t          beat_d, beat_q;

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept = bus.in_valid && bus.in_ready;

    regfile_param #(.NUM_REGS(NUM_REGS), .XLEN(XLEN), .AW(REG_AW)) u_rf (
        .clk(clk), .reset(reset), .we(wb_en), .waddr(wb_rd), .wdata(wb_data),
        .ra1(rs1), .ra2(rs2), .rd1(rd1), .rd2(rd2)
    );

`ifdef DECODE_WB_BYPASS_EN
    logic       wb_ok;
    logic [4:0] held_rs1, held_rs2;
    assign wb_ok = wb_en && wb_rd != 5'd0 && reg_ok(wb_rd, NUM_REGS);
    always_ff @(posedge clk or negedge reset)
        if (!reset) {held_rs1, held_rs2} <= '0;
        else if (accept) {held_rs1, held_rs2} <= {rs1, rs2};
`endif

    // Indices a format does not use are forced to x0 so they read 0 and never match a writeback.
    always_comb begin
        fmt = fmt_of(bus.in_instr[6:0]);
        rs1 = (fmt inside {IMM_R, IMM_I, IMM_S, IMM_B}) ? bus.in_instr[19:15] : 5'd0;
        rs2 = (fmt inside {IMM_R, IMM_S, IMM_B}) ? bus.in_instr[24:20] : 5'd0;
        rd = (fmt inside {IMM_R, IMM_I, IMM_U, IMM_J}) ? bus.in_instr[11:7] : 5'd0;
        illegal = fmt == IMM_X || !reg_ok(rs1, NUM_REGS) || !reg_ok(rs2, NUM_REGS) || !reg_ok(rd, NUM_REGS);
        beat_d.pc = bus.in_pc;
        beat_d.opcode = opcode_t'(bus.in_instr[6:0]);
        beat_d.funct3 = (fmt inside {IMM_U, IMM_J}) ? 3'd0 : bus.in_instr[14:12];
        beat_d.alu_control = illegal ? ALU_ADD
                           : alu_decode(opcode_t'(bus.in_instr[6:0]), bus.in_instr[14:12], bus.in_instr[30]);
        beat_d.rs1_data = rd1;
        beat_d.rs2_data = rd2;
`ifdef DECODE_WB_BYPASS_EN
        if (wb_ok && wb_rd == rs1) beat_d.rs1_data = wb_data;
        if (wb_ok && wb_rd == rs2) beat_d.rs2_data = wb_data;
`endif
        beat_d.imm = illegal ? '0 : imm_extend(fmt, bus.in_instr);
        beat_d.rd = rd;
        beat_d.reg_write = !illegal && rd != 5'd0;
        beat_d.illegal = illegal;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            valid_q <= 1'b0;
            beat_q <= '0;
        end else begin
            valid_q <= !bus.flush && (accept || (valid_q && !bus.out_ready));
            if (accept) beat_q <= beat_d;
`ifdef DECODE_WB_BYPASS_EN
            else if (valid_q && !bus.out_ready) begin
                if (wb_ok && wb_rd == held_rs1) beat_q.rs1_data <= wb_data;
                if (wb_ok && wb_rd == held_rs2) beat_q.rs2_data <= wb_data;
            end
`endif
        end

    assign bus.out_valid = valid_q;
    assign bus.out_pc = beat_q.pc;
    assign bus.out_opcode = beat_q.opcode;
    assign bus.out_funct3 = beat_q.funct3;
    assign bus.out_alu_control = beat_q.alu_control;
    assign bus.out_rs1_data = beat_q.rs1_data;
    assign bus.out_rs2_data = beat_q.rs2_data;
    assign bus.out_imm = beat_q.imm;
    assign bus.out_rd = beat_q.rd;
    assign bus.out_reg_write = beat_q.reg_write;
    assign bus.out_illegal = beat_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode_stage (32-register build plus a 16-register RV32E instance).
module tb_decode_stage;
`ifdef DECODE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic wb_en, wb16_en;
    logic [4:0] wb_rd, wb16_rd;
    logic [31:0] wb_data, wb16_data;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(32)) bus ();
    decode_stage_if #(.XLEN(32)) bus16 ();

    decode_stage #(.XLEN(32), .NUM_REGS(32)) dut (
        .clk(clk), .reset(reset), .bus(bus), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
    );
    decode_stage #(.XLEN(32), .NUM_REGS(16)) dut16 (
        .clk(clk), .reset(reset), .bus(bus16), .wb_en(wb16_en), .wb_rd(wb16_rd), .wb_data(wb16_data)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rw;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic        ill;
    } row_t;

    // sw x2,-4(x1) / beq x1,x2,-8 / lui x5,0x80000 / jal x1,2048 / jal x0,-2 / srai x6,x1,3 / bad opcode
    row_t rows [7] = '{
        '{32'hFE20AE23, 32'hFFFFFFFC, 5'd0, 1'b0, 3'd2, 4'd0,  1'b0},
        '{32'hFE208CE3, 32'hFFFFFFF8, 5'd0, 1'b0, 3'd0, 4'd1,  1'b0},
        '{32'h800002B7, 32'h80000000, 5'd5, 1'b1, 3'd0, 4'd10, 1'b0},
        '{32'h001000EF, 32'h00000800, 5'd1, 1'b1, 3'd0, 4'd0,  1'b0},
        '{32'hFFFFF06F, 32'hFFFFFFFE, 5'd0, 1'b0, 3'd0, 4'd0,  1'b0},
        '{32'h4030D313, 32'h00000403, 5'd6, 1'b1, 3'd5, 4'd7,  1'b0},
        '{32'h0000007F, 32'h00000000, 5'd0, 1'b0, 3'd0, 4'd0,  1'b1}
    };

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        bus.in_instr = instr;
        bus.in_pc = pc;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] data);
        wb_en = 1'b1;
        wb_rd = rd;
        wb_data = data;
        tick();
        wb_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        {bus.in_valid, bus.flush, bus.out_ready, bus16.in_valid, bus16.flush, bus16.out_ready} = '0;
        bus.in_instr = '0;
        bus.in_pc = '0;
        bus16.in_instr = '0;
        bus16.in_pc = '0;
        {wb_en, wb16_en} = '0;
        {wb_rd, wb16_rd} = '0;
        {wb_data, wb16_data} = '0;
        #2 reset = 1'b0;
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_imm", bus.out_imm, 0);
        chk("rst_out_rd", 32'(bus.out_rd), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        tick();
        reset = 1'b1;
        wb(5'd7, 32'h100);
        wb(5'd1, 32'h11);
        wb(5'd2, 32'h22);

        bus.out_ready = 1'b1;
        send(32'hFFF00293, 32'h1000);
        chk("addi_valid", 32'(bus.out_valid), 1);
        chk("addi_imm", bus.out_imm, 32'hFFFFFFFF);
        chk("addi_rd", 32'(bus.out_rd), 5);
        chk("addi_rw", 32'(bus.out_reg_write), 1);
        chk("addi_rs1", bus.out_rs1_data, 0);
        chk("addi_opcode", 32'(bus.out_opcode), 32'h13);
        chk("addi_pc", bus.out_pc, 32'h1000);

        send(32'h002081B3, 32'h1004);
        bus.out_ready = 1'b0;
        bus.in_instr = 32'h40110233;
        bus.in_pc = 32'h1008;
        bus.in_valid = 1'b1;
        #1;
        chk("stall_in_ready0", 32'(bus.in_ready), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_valid", 32'(bus.out_valid), 1);
            chk("stall_pc", bus.out_pc, 32'h1004);
            chk("stall_rs1", bus.out_rs1_data, 32'h11);
            chk("stall_rs2", bus.out_rs2_data, 32'h22);
            chk("stall_rd", 32'(bus.out_rd), 3);
            chk("stall_in_ready", 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        chk("sub_pc", bus.out_pc, 32'h1008);
        chk("sub_alu", 32'(bus.out_alu_control), 1);
        chk("sub_rs1", bus.out_rs1_data, 32'h22);
        chk("sub_rs2", bus.out_rs2_data, 32'h11);
        chk("sub_rd", 32'(bus.out_rd), 4);

        wb_en = 1'b1;
        wb_rd = 5'd7;
        wb_data = 32'h1234;
        send(32'h00538413, 32'h100C);
        wb_en = 1'b0;
        chk("byp_rs1", bus.out_rs1_data, BYP ? 32'h1234 : 32'h100);
        chk("byp_imm", bus.out_imm, 5);
        chk("byp_rs2", bus.out_rs2_data, 0);
        send(32'h00038493, 32'h1010);
        chk("x7_after_wb", bus.out_rs1_data, 32'h1234);

        bus.out_ready = 1'b0;
        bus.flush = 1'b1;
        bus.in_instr = 32'h00538413;
        bus.in_valid = 1'b1;
        wb(5'd10, 32'hABCD);
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_valid", 32'(bus.out_valid), 0);
        bus.out_ready = 1'b1;
        send(32'h00050593, 32'h1014);
        chk("flush_wb_valid", 32'(bus.out_valid), 1);
        chk("flush_wb_rs1", bus.out_rs1_data, 32'hABCD);
        bus.out_ready = 1'b0;
        wb(5'd10, 32'h77);
        chk("held_valid", 32'(bus.out_valid), 1);
        chk("held_rs1", bus.out_rs1_data, BYP ? 32'h77 : 32'hABCD);
        bus.out_ready = 1'b1;

        foreach (rows[r]) begin
            send(rows[r].instr, 32'h2000 + 32'(r) * 4);
            chk("tbl_imm", bus.out_imm, rows[r].imm);
            chk("tbl_rd", 32'(bus.out_rd), 32'(rows[r].rd));
            chk("tbl_rw", 32'(bus.out_reg_write), 32'(rows[r].rw));
            chk("tbl_f3", 32'(bus.out_funct3), 32'(rows[r].f3));
            chk("tbl_alu", 32'(bus.out_alu_control), 32'(rows[r].alu));
            chk("tbl_ill", 32'(bus.out_illegal), 32'(rows[r].ill));
        end

        bus16.out_ready = 1'b1;
        wb16_en = 1'b1;
        wb16_rd = 5'd4;
        wb16_data = 32'h44;
        tick();
        wb16_rd = 5'd20;
        wb16_data = 32'hDEAD;
        tick();
        wb16_en = 1'b0;
        bus16.in_instr = 32'h002088B3;
        bus16.in_valid = 1'b1;
        tick();
        chk("e_x17_valid", 32'(bus16.out_valid), 1);
        chk("e_x17_illegal", 32'(bus16.out_illegal), 1);
        chk("e_x17_rw", 32'(bus16.out_reg_write), 0);
        bus16.in_instr = 32'h00020293;
        tick();
        bus16.in_valid = 1'b0;
        chk("e_x4_rs1", bus16.out_rs1_data, 32'h44);
        chk("e_x4_illegal", 32'(bus16.out_illegal), 0);

        send(32'h002081B3, 32'h3000);
        bus.out_ready = 1'b0;
        tick();
        chk("pre_reset_valid", 32'(bus.out_valid), 1);
        reset = 1'b0;
        #1;
        chk("async_reset_valid", 32'(bus.out_valid), 0);
        chk("async_reset_rs1", bus.out_rs1_data, 0);
        tick();
        reset = 1'b1;
        bus.out_ready = 1'b1;
        send(32'h002081B3, 32'h3004);
        chk("post_x1", bus.out_rs1_data, 0);
        chk("post_x2", bus.out_rs2_data, 0);
        send(32'h00538413, 32'h3008);
        chk("post_x7", bus.out_rs1_data, 0);
        send(32'h00050593, 32'h300C);
        chk("post_x10", bus.out_rs1_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
